// File: rtl/fetch_prefetch_pkg.sv
// Shared types and sizing for the fetch/prefetch stage.
// FETCH_MISALIGN_CHK_EN (in the top) decides whether misaligned redirect targets fault or get aligned.
package fetch_prefetch_pkg;

   localparam int FETCH_WIDTH   = 32;
   localparam int FETCH_DEPTH   = 4;
   localparam int FETCH_MAX_OUT = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_FAULT
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_WIDTH-1:0] pc;
      logic [FETCH_WIDTH-1:0] instr;
   } fetch_entry_t;

   function automatic logic [FETCH_WIDTH-1:0] word_align(input logic [FETCH_WIDTH-1:0] addr);
      return addr & ~(FETCH_WIDTH'(3));
   endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; push and pop may coincide at any fill level.
module fetch_prefetch_fifo
   import fetch_prefetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~flush & (~full | pop);
      do_pop   = pop & ~flush & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: sequential imem fetches, credit-limited prefetch FIFO, redirect flush with stale-response discard.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets in S_FAULT (sticky fetch_fault).
module fetch_prefetch
   import fetch_prefetch_pkg::*;
#(
   parameter logic [FETCH_WIDTH-1:0] RESET_PC = '0,
   parameter int                     DEPTH    = FETCH_DEPTH,
   parameter int                     MAX_OUT  = FETCH_MAX_OUT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redirect_valid,
   input  logic [FETCH_WIDTH-1:0] redirect_pc,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [FETCH_WIDTH-1:0] imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [FETCH_WIDTH-1:0] imem_rsp_data,
   output logic                   if_valid,
   input  logic                   if_ready,
   output logic [FETCH_WIDTH-1:0] if_instr,
   output logic [FETCH_WIDTH-1:0] if_pc,
   output logic                   fetch_fault
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IW    = $clog2(MAX_OUT + 1);
   localparam int SW    = CNT_W + 1;
   localparam logic [FETCH_WIDTH-1:0] WORD_BYTES = FETCH_WIDTH'(4);

   fetch_state_e           state_q;
   logic [FETCH_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_target;
   logic [IW-1:0]          inflight_q, inflight_d, discard_q, discard_d;
   logic [CNT_W-1:0]       fifo_count;
   logic [SW-1:0]          credit_used;
   logic                   misaligned, req_fire, rsp_keep, fifo_pop, fifo_full, fifo_empty;
   fetch_entry_t           rsp_entry, head_entry;

`ifdef FETCH_MISALIGN_CHK_EN
   logic fault_q;
   assign misaligned  = (redirect_pc[1:0] != 2'b00);
   assign fetch_fault = fault_q;
`else
   assign misaligned  = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   assign redirect_target = word_align(redirect_pc);

   // Slots already promised = buffered + in flight, minus responses that will be thrown away.
   assign credit_used = SW'(fifo_count) + SW'(inflight_q) - SW'(discard_q);

   assign imem_req_valid = (state_q == S_FETCH) & ~redirect_valid & ~fifo_full &
                           (inflight_q < IW'(MAX_OUT)) & (credit_used < SW'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign rsp_keep       = imem_rsp_valid & ~redirect_valid & (discard_q == '0);
   assign fifo_pop       = if_valid & if_ready & ~redirect_valid;
   assign rsp_entry      = '{pc: rsp_pc_q, instr: imem_rsp_data};

   assign if_valid = ~fifo_empty;
   assign if_instr = head_entry.instr;
   assign if_pc    = head_entry.pc;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q + IW'(req_fire) - IW'(imem_rsp_valid);
      discard_d  = discard_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_target;
         rsp_pc_d   = redirect_target;
         discard_d  = inflight_q - IW'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + WORD_BYTES;
         if (rsp_keep) rsp_pc_d = rsp_pc_q + WORD_BYTES;
         if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   // A redirect always wins; a misaligned one parks the stage until an aligned target arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
`ifdef FETCH_MISALIGN_CHK_EN
         fault_q <= 1'b0;
`endif
      end else if (redirect_valid) begin
         state_q <= misaligned ? S_FAULT : S_FETCH;
`ifdef FETCH_MISALIGN_CHK_EN
         fault_q <= misaligned;
`endif
      end else if (state_q == S_IDLE) begin
         state_q <= S_FETCH;
      end
   end

   fetch_prefetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_keep),
      .push_entry(rsp_entry),
      .pop       (fifo_pop),
      .flush     (redirect_valid),
      .head      (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: behavioural imem, expected fetch stream queue, decoupled pop monitor.
module tb_fetch_prefetch;
   import fetch_prefetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = FETCH_DEPTH;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        fetch_fault;

   pend_t       pend[$];
   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          last_due = 0;
   int          fires_since = 0;
   int          pops_since = 0;
   int          pops_total = 0;
   int          p0;
   int          stale;
   bit          found;
   bit          fault_exp = 1'b0;
   logic [31:0] exp_req_addr = RESET_PC;

   fetch_prefetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .fetch_fault   (fetch_fault)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Instruction memory: records accepted requests, each fire extends the expected fetch stream.
   initial forever begin : imem_accept
      pend_t p;
      int    d;
      @(negedge clk);
      if (rst_n) begin
         if (fault_exp) checkOutput("req_valid_in_fault", {31'b0, imem_req_valid}, 32'h0);
         if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
         if (imem_req_valid && imem_req_ready) begin
            checkOutput("req_addr", imem_req_addr, exp_req_addr);
            d = cyc + 1 + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            p.addr = imem_req_addr;
            p.due  = d;
            pend.push_back(p);
            exp_q.push_back('{exp_req_addr, mem_word(exp_req_addr)});
            exp_req_addr += 32'd4;
            fires_since++;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc + 1) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   end

   // Monitor: every accepted pop is compared against the head of the expected stream.
   initial forever begin : pop_monitor
      exp_t e;
      @(negedge clk);
      if (rst_n && if_valid && if_ready && !redirect_valid) begin
         pops_total++;
         pops_since++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL pop_unexpected: got pc %h, expected no entry", if_pc);
         end else begin
            e = exp_q.pop_front();
            checkOutput("if_pc", if_pc, e.pc);
            checkOutput("if_instr", if_instr, e.instr);
         end
      end
   end

   task automatic setInputs(input bit redir, input logic [31:0] target, input bit ifr, input bit mr);
      if_ready       = ifr;
      imem_req_ready = mr;
      redirect_valid = redir;
      redirect_pc    = redir ? target : $urandom;
      if (redir) begin
         exp_q.delete();
         fires_since = 0;
         pops_since  = 0;
         exp_req_addr = target & ~32'h3;
`ifdef FETCH_MISALIGN_CHK_EN
         fault_exp = (target[1:0] != 2'b00);
`endif
      end
   endtask

   task automatic applyStimulus(input bit redir, input logic [31:0] target, input bit ifr, input bit mr);
      @(posedge clk);
      #2;
      setInputs(redir, target, ifr, mr);
   endtask

   task automatic waitPops(input int n, input int budget);
      for (int i = 0; i < budget && pops_since < n; i++) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      checkOutput("pops_reached", 32'(pops_since >= n), 32'h1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      setInputs(0, 32'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
      checkOutput("rst_fault", {31'b0, fetch_fault}, 32'h0);
      checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
      checkOutput("rst_if_pc", if_pc, 32'h0);
      checkOutput("rst_if_instr", if_instr, 32'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Streaming with 1-cycle memory: one instruction per cycle once warm.
      repeat (10) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      p0 = pops_total;
      repeat (20) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("throughput", 32'(pops_total - p0), 32'd20);

      // Decode stall fills the FIFO exactly, then drains 0,4,8,C back to back.
      applyStimulus(1, 32'h0, 1'b0, 1'b1);
      repeat (20) applyStimulus(0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("stall_inflight", 32'(pend.size()), 32'h0);
      checkOutput("stall_buffered", 32'(fires_since), 32'(DEPTH));
      checkOutput("stall_if_valid", {31'b0, if_valid}, 32'h1);
      repeat (4) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("drain_pops", 32'(pops_since), 32'd4);

      // Redirect with two requests in flight on a 3-cycle memory.
      lat_min = 3;
      lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus(0, 32'h0, 1'b1, 1'b1);
         if (pend.size() == 2) found = 1'b1;
      end
      checkOutput("two_inflight_seen", {31'b0, found}, 32'h1);
      setInputs(1, 32'h100, 1'b1, 1'b1);
      applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("flush_empty", {31'b0, if_valid}, 32'h0);
      waitPops(3, 40);

      // Redirect coinciding with a response and a pop.
      lat_min = 2;
      lat_max = 2;
      found = 1'b0;
      stale = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         applyStimulus(0, 32'h0, 1'b1, 1'b1);
         if (imem_rsp_valid && if_valid) begin
            found = 1'b1;
            stale = pend.size() - 1;
            setInputs(1, 32'h300, 1'b1, 1'b1);
         end
      end
      checkOutput("rsp_pop_redirect_seen", {31'b0, found}, 32'h1);
      $display("[TB] redirect with rsp: %0d stale responses still due", stale);
      waitPops(4, 40);

      // Address wrap at the top of the 32-bit space.
      lat_min = 1;
      lat_max = 1;
      applyStimulus(1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      repeat (10) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("wrap_fires", 32'(fires_since >= 3), 32'h1);

      // Misaligned redirect target.
      applyStimulus(1, 32'h102, 1'b1, 1'b1);
      repeat (2) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
`ifdef FETCH_MISALIGN_CHK_EN
      checkOutput("fault_set", {31'b0, fetch_fault}, 32'h1);
      checkOutput("fault_no_req", {31'b0, imem_req_valid}, 32'h0);
      applyStimulus(1, 32'h200, 1'b1, 1'b1);
      repeat (2) applyStimulus(0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("fault_cleared", {31'b0, fetch_fault}, 32'h0);
`else
      checkOutput("fault_tied_low", {31'b0, fetch_fault}, 32'h0);
`endif
      waitPops(2, 40);

      // Randomised traffic with random readiness, latency and redirects.
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(99, 0) < 3, $urandom & 32'h0000_FFFF,
                       $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
      end
      if (fault_exp) applyStimulus(1, 32'h400, 1'b1, 1'b1);

      // Asynchronous reset in the middle of traffic.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("async_rst_if_valid", {31'b0, if_valid}, 32'h0);
      checkOutput("async_rst_req_addr", imem_req_addr, RESET_PC);
      pend.delete();
      exp_q.delete();
      exp_req_addr = RESET_PC;
      fault_exp = 1'b0;
      pops_since = 0;
      fires_since = 0;
      setInputs(0, 32'h0, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      lat_min = 1;
      lat_max = 1;
      waitPops(20, 60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
